alu_simd_serial: RTL and testbench
==================================

# alu_simd_serial

Time-multiplexed counterpart of the parallel SIMD adder bank: accepts one vector of N W-bit lane operand pairs through a valid/ready handshake and pushes the lanes one per cycle through a single shared W-bit add/sub unit. It reassembles the results into an N-lane output vector, presented under its own valid/ready handshake. It trades throughput for area: one adder instead of N, and no DSP inference. It sits where lane vectors arrive at low rate and DSP slices are scarce.

## Interface
- N, 4: number of lanes; N ≥ 2.
- W, 10: lane width in bits; W ≥ 2.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  input vector valid.
- ready_o  out  1  block can accept a vector; combinational from state, high only in IDLE.
- op_i  in  1  0 = add, 1 = subtract; applies to all lanes of the vector.
- a_i  in  [W-1:0] x [N-1:0]  lane operands A, unpacked array, lane 0 = a_i[0].
- b_i  in  [W-1:0] x [N-1:0]  lane operands B.
- valid_o  out  1  result vector valid; registered.
- ready_i  in  1  downstream accepts result.
- res_o  out  [W-1:0] x [N-1:0]  lane results.
- carry_o  out  N  per-lane carry (add) or borrow (sub).

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - On an edge with valid_i=1: capture a_i, b_i, op_i into internal registers, set lane index to 0, go to CALC.
- CALC:
  - Each edge computes lane idx from the captured operands. Write res[idx] and carry[idx], then increment idx.
  - On the edge that computes lane N-1, go to DONE.
  - Lanes are processed in order 0 … N-1.
- DONE:
  - valid_o=1; res_o and carry_o are held stable.
  - On an edge with ready_i=1: clear valid_o and go to IDLE.
- ready_o=0 in CALC and DONE. valid_i is ignored there; a vector is never accepted while one is in flight.
- Input ports are sampled only on the accept edge. Later changes to a_i, b_i, op_i have no effect on the vector in flight.
- Arithmetic per lane:
  - add: {carry, res} = a + b over W+1 bits.
  - sub: res = (a − b) mod 2^W; carry = 1 iff a < b (unsigned borrow).
- res_o/carry_o change only on CALC edges and on reset. Their values while valid_o=0 are deterministic but not part of the contract.
- Reset (any state, including mid-CALC or DONE):
  - The in-flight vector is discarded; the FSM goes to IDLE.
  - valid_o=0, res_o all 0, carry_o=0, lane index=0, captured operands=0.
- ready_o is 1 from the first cycle the FSM is in IDLE, including while rst_i is held. An accept is only effective on an edge where rst_i=0; reset has priority over valid_i.

## Timing
- Accept edge E0, where valid_i & ready_o.
- Lane k is written on edge E(k+1).
- valid_o rises after edge EN: latency N cycles from accept to valid_o.
- The output handshake completes on the first edge with valid_o & ready_i. The FSM is IDLE, with ready_o=1, in the following cycle.
- Minimum vector period is N+2 cycles: accept, N CALC, one DONE.
- ready_i has no effect outside DONE. ready_i=1 held permanently gives exactly one DONE cycle per vector.
- Backpressure is unbounded. DONE holds indefinitely with outputs stable.

## Structure
- Package alu_simd_pkg:
  - typedef enum state_t {IDLE, CALC, DONE}.
  - typedef enum op_t {OP_ADD, OP_SUB}.
- Sub-module lane_addsub: purely combinational W-bit add/sub with carry/borrow out. It is instantiated once and muxed by lane index.
- The lane index counter is $clog2(N) bits wide and is compared against N-1; no wrap logic is needed.

## Test plan
- Reset: hold rst_i for 3 cycles, then release.
  - While held and after release: valid_o=0, res_o all 0, carry_o=0.
  - ready_o=1 from the first IDLE cycle, including while rst_i is held.
- Add, N=4, W=10: a={1,2,3,1023}, b={1,2,3,1}, op=0, ready_i=1.
  - valid_o rises exactly 4 cycles after accept.
  - res_o={2,4,6,0}, carry_o=4'b1000.
- Subtract: a={5,0,512,7}, b={3,1,512,9}, op=1.
  - res_o={2,1023,0,1022}, carry_o=4'b1010.
- Backpressure and isolation: ready_i=0 for 10 cycles after valid_o.
  - valid_o and res_o stay stable.
  - valid_i pulses during CALC/DONE are not accepted.
  - Changing a_i during CALC does not alter results.
- Reset mid-CALC: assert rst_i on the 2nd CALC cycle.
  - Next cycle: IDLE, outputs zero.
  - A following vector a={10,20,30,40}, b={1,1,1,1} add yields {11,21,31,41}.
- Streaming: valid_i and ready_i held high with 5 random vectors.
  - Accepts occur every N+2=6 cycles.
  - All results match the reference model; no vector is lost or duplicated.

Source files
------------

// File: rtl/alu_simd_serial_pkg.sv
// Shared types for the serial SIMD add/sub block: FSM states and lane operation.
package alu_simd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/alu_simd_serial_if.sv
// Vector-in / vector-out bus of the serial SIMD add/sub block.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable from raising valid until that edge.
interface alu_simd_serial_if #(
    parameter int N = 4,
    parameter int W = 10
);
    logic         valid_i;
    logic         ready_o;
    logic         op_i;
    logic [W-1:0] a_i [N];
    logic [W-1:0] b_i [N];
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] res_o [N];
    logic [N-1:0] carry_o;

    modport slave (
        input  valid_i, op_i, a_i, b_i, ready_i,
        output ready_o, valid_o, res_o, carry_o
    );

    modport master (
        output valid_i, op_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, res_o, carry_o
    );
endinterface

// File: rtl/alu_simd_serial_lane_addsub.sv
// Single shared W-bit add/sub unit; carry_o is carry-out on add, unsigned borrow on sub.
module lane_addsub
    import alu_simd_pkg::*;
#(
    parameter int W = 10
) (
    input  op_t          op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic         carry_o
);
    logic [W:0] sum;

    // The W+1-bit difference wraps negative, so its MSB is exactly the borrow.
    always_comb begin
        sum = '0;
        if (op_i == OP_SUB) begin
            sum = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            sum = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign res_o   = sum[W-1:0];
    assign carry_o = sum[W];
endmodule

// File: rtl/alu_simd_serial.sv
// Serial SIMD add/sub: captures one N-lane vector, computes one lane per cycle
// through a single lane_addsub, then presents the whole result vector.
module alu_simd_serial
    import alu_simd_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_simd_serial_if.slave    bus,
    output state_t              dbg_state_o
);
    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    op_t            op_q, op_d;
    logic [W-1:0]   a_q [N];
    logic [W-1:0]   a_d [N];
    logic [W-1:0]   b_q [N];
    logic [W-1:0]   b_d [N];
    logic [W-1:0]   res_q [N];
    logic [W-1:0]   res_d [N];
    logic [N-1:0]   carry_q, carry_d;
    logic           valid_q, valid_d;

    logic [W-1:0]   lane_res;
    logic           lane_carry;

    lane_addsub #(.W(W)) u_lane (
        .op_i    (op_q),
        .a_i     (a_q[idx_q]),
        .b_i     (b_q[idx_q]),
        .res_o   (lane_res),
        .carry_o (lane_carry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    op_d    = op_t'(bus.op_i);
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d[idx_q]   = lane_res;
                carry_d[idx_q] = lane_carry;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // valid_o is a flop that tracks the next state, so it is high exactly in DONE.
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= OP_ADD;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            res_q   <= '{default: '0};
            carry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = valid_q;
    assign bus.res_o   = res_q;
    assign bus.carry_o = carry_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_alu_simd_serial.sv
// Directed bench for alu_simd_serial (N=4, W=10): reset, add, sub, backpressure,
// mid-CALC reset and streaming, checked with immediate assertions.
module tb_alu_simd_serial;
    import alu_simd_pkg::*;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int RW = N * W + N;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] exp_q [$];

    alu_simd_serial_if #(.N(N), .W(W)) bus ();

    alu_simd_serial #(.N(N), .W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] dut_out();
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = bus.res_o[i];
        r[N*W +: N] = bus.carry_o;
        return r;
    endfunction

    // reference: {carry[N-1:0], res[N-1], ..., res[0]}
    function automatic logic [RW-1:0] model(input logic [W-1:0] a [N], input logic [W-1:0] b [N],
                                            input logic op);
        logic [RW-1:0] r;
        int unsigned   s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (op == 1'b0) begin
                s = int'(a[i]) + int'(b[i]);
                r[i*W +: W] = W'(s % (1 << W));
                r[N*W + i]  = (s >= (1 << W));
            end else begin
                r[i*W +: W] = W'((int'(a[i]) - int'(b[i]) + (1 << W)) % (1 << W));
                r[N*W + i]  = (a[i] < b[i]);
            end
        end
        return r;
    endfunction

    // driver
    task automatic drive_vec(input logic [W-1:0] a [N], input logic [W-1:0] b [N], input logic op);
        bus.a_i  = a;
        bus.b_i  = b;
        bus.op_i = op;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.valid_o && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];
    logic         vop;
    int           lat;
    int           n_acc, n_got, cyc;
    int           acc_cyc [5];
    logic         new_vec;
    logic [RW-1:0] e;

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.op_i    = 1'b0;
        bus.a_i     = '{default: '0};
        bus.b_i     = '{default: '0};

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", bus.ready_o, 1'b1);
            check("rst_valid", bus.valid_o, 1'b0);
            check("rst_out", dut_out(), '0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_valid", bus.valid_o, 1'b0);
        check("post_rst_out", dut_out(), '0);
        check("post_rst_ready", bus.ready_o, 1'b1);

        // add with overflow in lane 3
        va = '{10'd1, 10'd2, 10'd3, 10'd1023};
        vb = '{10'd1, 10'd2, 10'd3, 10'd1};
        drive_vec(va, vb, 1'b0);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        check("add_busy", bus.ready_o, 1'b0);
        wait_valid(lat);
        check("add_latency", lat, 4);
        check("add_res", dut_out(), {4'b1000, 10'd0, 10'd6, 10'd4, 10'd2});
        tick();
        check("add_done_valid", bus.valid_o, 1'b0);
        check("add_done_ready", bus.ready_o, 1'b1);

        // subtract with backpressure, input disturbances while busy
        va = '{10'd5, 10'd0, 10'd512, 10'd7};
        vb = '{10'd3, 10'd1, 10'd512, 10'd9};
        drive_vec(va, vb, 1'b1);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b0;
        tick();
        bus.a_i  = '{default: 10'h3ff};
        bus.op_i = 1'b0;
        tick();
        check("sub_calc_state", dbg_state, CALC);
        wait_valid(lat);
        check("sub_latency", lat, 3);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", bus.valid_o, 1'b1);
            check("bp_res", dut_out(), {4'b1010, 10'd1022, 10'd0, 10'd1023, 10'd2});
            check("bp_ready", bus.ready_o, 1'b0);
            tick();
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        check("bp_release_state", dbg_state, IDLE);
        check("bp_release_valid", bus.valid_o, 1'b0);
        tick();
        check("no_extra_accept", dbg_state, IDLE);

        // reset on second CALC cycle
        va = '{10'd100, 10'd200, 10'd300, 10'd400};
        vb = '{10'd1, 10'd1, 10'd1, 10'd1};
        drive_vec(va, vb, 1'b0);
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        tick();
        check("mid_lane0", bus.res_o[0], 10'd101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", dbg_state, IDLE);
        check("midrst_out", dut_out(), '0);
        check("midrst_valid", bus.valid_o, 1'b0);
        check("midrst_ready", bus.ready_o, 1'b1);

        va = '{10'd10, 10'd20, 10'd30, 10'd40};
        drive_vec(va, vb, 1'b0);
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        wait_valid(lat);
        check("after_rst_latency", lat, 4);
        check("after_rst_res", dut_out(), {4'b0000, 10'd41, 10'd31, 10'd21, 10'd11});
        tick();

        // streaming with valid_i and ready_i held high
        n_acc = 0;
        n_got = 0;
        cyc   = 0;
        for (int i = 0; i < N; i++) begin
            va[i] = W'($urandom_range(0, 1023));
            vb[i] = W'($urandom_range(0, 1023));
        end
        vop = 1'($urandom_range(0, 1));
        drive_vec(va, vb, vop);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        while (n_got < 5 && cyc < 200) begin
            if (bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL stream_extra observed=result expected=none pending");
                end else begin
                    e = exp_q.pop_front();
                    check("stream_res", dut_out(), e);
                end
                n_got++;
            end
            new_vec = 1'b0;
            if (bus.ready_o && bus.valid_i) begin
                exp_q.push_back(model(va, vb, vop));
                acc_cyc[n_acc] = cyc;
                n_acc++;
                new_vec = 1'b1;
            end
            tick();
            cyc++;
            if (new_vec) begin
                if (n_acc < 5) begin
                    for (int i = 0; i < N; i++) begin
                        va[i] = W'($urandom_range(0, 1023));
                        vb[i] = W'($urandom_range(0, 1023));
                    end
                    vop = 1'($urandom_range(0, 1));
                    drive_vec(va, vb, vop);
                end else begin
                    bus.valid_i = 1'b0;
                end
            end
        end
        check("stream_accepts", n_acc, 5);
        check("stream_results", n_got, 5);
        check("stream_leftover", exp_q.size(), 0);
        for (int i = 1; i < 5; i++) begin
            if (i < n_acc) check("stream_period", acc_cyc[i] - acc_cyc[i-1], N + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
